// File: rtl/mmio_shadow_regfile_if.sv
// Host byte-bus bundle for the shadow register file: strobes, address, data and read return.
interface mmio_shadow_regfile_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          cs;
  logic          rd;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rvalid;

  modport master (output cs, rd, wr, addr, wdata, input rdata, rvalid);
  modport slave  (input cs, rd, wr, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/mmio_shadow_regfile.sv
// Multi-channel MMIO register map with shadow/active configuration copies and deferred commit.
module mmio_shadow_regfile #(
  parameter int unsigned DW    = 8,
  parameter int unsigned NCH   = 2,
  parameter int unsigned CH_AW = 7,
  parameter int unsigned AW    = 8,
  parameter int unsigned NCFG  = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  mmio_shadow_regfile_if.slave     bus,
  input  logic [NCH-1:0]           core_busy_i,
  output logic [NCH*NCFG*DW-1:0]   active_cfg_o,
  output logic [NCH-1:0]           reg_mode_o,
  output logic [NCH-1:0]           dt_mode_o,
  output logic [NCH*DW-1:0]        dt_ext_o,
  output logic [NCH-1:0]           cfg_updated_o,
  output logic                     err_irq_o
);

  localparam int unsigned CHW      = AW - CH_AW;
  localparam int unsigned CIW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned IW       = (NCFG > 1) ? $clog2(NCFG) : 1;
  localparam int unsigned CFG_BASE = 16;

  logic [NCH-1:0][NCFG-1:0][DW-1:0] shadow_q, shadow_d;
  logic [NCH-1:0][NCFG-1:0][DW-1:0] active_q, active_d;
  logic [NCH-1:0][DW-1:0]           dt_ext_q, dt_ext_d;
  logic [NCH-1:0]                   reg_mode_q, reg_mode_d;
  logic [NCH-1:0]                   dt_mode_q, dt_mode_d;
  logic [NCH-1:0]                   pend_q, pend_d;
  logic [NCH-1:0]                   err_q, err_d;
  logic [NCH-1:0]                   cfg_upd_q, cfg_upd_d;
  logic                             err_irq_q, err_irq_d;
  logic [DW-1:0]                    rdata_q, rdata_d;
  logic                             rvalid_q, rvalid_d;

  logic [CHW-1:0]   ch_c;
  logic [CH_AW-1:0] off_c;
  logic [CIW-1:0]   ch_idx_c;
  logic [IW-1:0]    cfg_idx_c;
  logic             ch_ok_c;
  logic             cfg_hit_c;
  logic             legal_c;
  logic             we_c;
  logic             re_c;
  logic [DW-1:0]    rd_val_c;

  // Address decode into channel and per-channel offset.
  assign ch_c      = bus.addr[AW-1:CH_AW];
  assign off_c     = bus.addr[CH_AW-1:0];
  assign ch_idx_c  = CIW'(ch_c);
  assign ch_ok_c   = (32'(ch_c) < NCH);
  assign cfg_hit_c = (32'(off_c) >= CFG_BASE) && (32'(off_c) < CFG_BASE + NCFG);
  assign cfg_idx_c = IW'(32'(off_c) - CFG_BASE);
  assign legal_c   = (off_c <= CH_AW'(3)) || cfg_hit_c;
  assign we_c      = bus.cs & bus.wr;
  assign re_c      = bus.cs & bus.rd & ~bus.wr;

  // Read data mux; unmapped offsets and absent channels return zero.
  always_comb begin
    rd_val_c = '0;
    if (ch_ok_c) begin
      case (off_c)
        CH_AW'(0): rd_val_c = DW'(2);
        CH_AW'(1): rd_val_c = DW'({dt_mode_q[ch_idx_c], reg_mode_q[ch_idx_c], 1'b0});
        CH_AW'(2): rd_val_c = DW'({core_busy_i[ch_idx_c], err_q[ch_idx_c], pend_q[ch_idx_c]});
        CH_AW'(3): rd_val_c = dt_ext_q[ch_idx_c];
        default: begin
          if (cfg_hit_c) rd_val_c = shadow_q[ch_idx_c][cfg_idx_c];
        end
      endcase
    end
  end

  // Next-state: commit copies use pre-edge shadow, then the bus access is applied.
  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    dt_ext_d   = dt_ext_q;
    reg_mode_d = reg_mode_q;
    dt_mode_d  = dt_mode_q;
    pend_d     = pend_q;
    err_d      = err_q;
    cfg_upd_d  = '0;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;

    for (int c = 0; c < NCH; c++) begin
      if (pend_q[c] && !core_busy_i[c]) begin
        active_d[c]  = shadow_q[c];
        pend_d[c]    = 1'b0;
        cfg_upd_d[c] = 1'b1;
      end
    end

    if (re_c) begin
      rdata_d  = rd_val_c;
      rvalid_d = 1'b1;
    end

    if ((we_c || re_c) && ch_ok_c && !legal_c) err_d[ch_idx_c] = 1'b1;

    if (we_c && ch_ok_c && legal_c) begin
      case (off_c)
        CH_AW'(1): begin
          reg_mode_d[ch_idx_c] = bus.wdata[1];
          dt_mode_d[ch_idx_c]  = bus.wdata[2];
          // A commit while one is already pending folds into that one.
          if (bus.wdata[0] && !pend_q[ch_idx_c]) pend_d[ch_idx_c] = 1'b1;
        end
        CH_AW'(2): begin
          if (bus.wdata[1]) err_d[ch_idx_c] = 1'b0;
        end
        CH_AW'(3): begin
          if (dt_mode_q[ch_idx_c]) err_d[ch_idx_c] = 1'b1;
          else dt_ext_d[ch_idx_c] = bus.wdata;
        end
        default: begin
          if (cfg_hit_c) shadow_d[ch_idx_c][cfg_idx_c] = bus.wdata;
        end
      endcase
    end

    err_irq_d = |err_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q   <= '0;
      active_q   <= '0;
      dt_ext_q   <= '0;
      reg_mode_q <= '0;
      dt_mode_q  <= '0;
      pend_q     <= '0;
      err_q      <= '0;
      cfg_upd_q  <= '0;
      err_irq_q  <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      dt_ext_q   <= dt_ext_d;
      reg_mode_q <= reg_mode_d;
      dt_mode_q  <= dt_mode_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      cfg_upd_q  <= cfg_upd_d;
      err_irq_q  <= err_irq_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign active_cfg_o  = active_q;
  assign reg_mode_o    = reg_mode_q;
  assign dt_mode_o     = dt_mode_q;
  assign dt_ext_o      = dt_ext_q;
  assign cfg_updated_o = cfg_upd_q;
  assign err_irq_o     = err_irq_q;

endmodule

// File: tb/tb_mmio_shadow_regfile.sv
// Bench for mmio_shadow_regfile: behavioural register-map model plus directed literal checks.
module tb_mmio_shadow_regfile;
  localparam int unsigned DW    = 8;
  localparam int unsigned NCH   = 2;
  localparam int unsigned CH_AW = 7;
  localparam int unsigned AW    = 9;
  localparam int unsigned NCFG  = 64;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0]         busy;
  logic [NCH*NCFG*DW-1:0] active_cfg;
  logic [NCH-1:0]         reg_mode, dt_mode, cfg_updated;
  logic [NCH*DW-1:0]      dt_ext;
  logic                   err_irq;

  always #5 clk = ~clk;

  mmio_shadow_regfile_if #(.AW(AW), .DW(DW)) bus_if ();

  mmio_shadow_regfile #(.DW(DW), .NCH(NCH), .CH_AW(CH_AW), .AW(AW), .NCFG(NCFG)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus_if), .core_busy_i(busy),
    .active_cfg_o(active_cfg), .reg_mode_o(reg_mode), .dt_mode_o(dt_mode),
    .dt_ext_o(dt_ext), .cfg_updated_o(cfg_updated), .err_irq_o(err_irq)
  );

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  // Model state: what software sees and what the cores see.
  logic [DW-1:0]  sh_m  [NCH][NCFG];
  logic [DW-1:0]  ac_m  [NCH][NCFG];
  logic [DW-1:0]  dtx_m [NCH];
  logic [NCH-1:0] rm_m, dm_m, pend_m, err_m, exp_upd;
  logic [DW-1:0]  exp_rdata;
  logic           exp_rvalid;

  function automatic logic [AW-1:0] A(int ch, int off);
    return AW'(ch * (1 << CH_AW) + off);
  endfunction

  function automatic bit legal_off(int off);
    return (off <= 3) || (off >= 16 && off < 16 + NCFG);
  endfunction

  function automatic logic [DW-1:0] model_read(int ch, int off);
    if (ch >= NCH) return '0;
    case (off)
      0: return DW'(2);
      1: return DW'(dm_m[ch] * 4 + rm_m[ch] * 2);
      2: return DW'(busy[ch] * 4 + err_m[ch] * 2 + pend_m[ch]);
      3: return dtx_m[ch];
      default: return (off >= 16 && off < 16 + NCFG) ? sh_m[ch][off-16] : '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] act(int c, int i);
    return active_cfg[(c*NCFG+i)*DW +: DW];
  endfunction

  task automatic lit(string name, logic [31:0] actual, logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Model update at every edge, from the register-map rules.
  always @(posedge clk) begin : model
    int ch, off;
    logic [NCH-1:0] was_pend;
    started = 1'b1;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        for (int i = 0; i < NCFG; i++) begin
          sh_m[c][i] = '0;
          ac_m[c][i] = '0;
        end
        dtx_m[c] = '0;
      end
      rm_m = '0; dm_m = '0; pend_m = '0; err_m = '0; exp_upd = '0;
      exp_rdata = '0; exp_rvalid = 1'b0;
    end else begin
      ch = int'(bus_if.addr) / (1 << CH_AW);
      off = int'(bus_if.addr) % (1 << CH_AW);
      exp_rvalid = 1'b0;
      exp_upd = '0;
      if (bus_if.cs && bus_if.rd && !bus_if.wr) begin
        exp_rdata = model_read(ch, off);
        exp_rvalid = 1'b1;
      end
      was_pend = pend_m;
      for (int c = 0; c < NCH; c++) begin
        if (pend_m[c] && !busy[c]) begin
          for (int i = 0; i < NCFG; i++) ac_m[c][i] = sh_m[c][i];
          pend_m[c] = 1'b0;
          exp_upd[c] = 1'b1;
        end
      end
      if (bus_if.cs && (bus_if.rd || bus_if.wr) && ch < NCH && !legal_off(off)) err_m[ch] = 1'b1;
      if (bus_if.cs && bus_if.wr && ch < NCH && legal_off(off)) begin
        if (off == 1) begin
          rm_m[ch] = bus_if.wdata[1];
          dm_m[ch] = bus_if.wdata[2];
          if (bus_if.wdata[0] && !was_pend[ch]) pend_m[ch] = 1'b1;
        end else if (off == 2) begin
          if (bus_if.wdata[1]) err_m[ch] = 1'b0;
        end else if (off == 3) begin
          if (dm_m[ch]) err_m[ch] = 1'b1;
          else dtx_m[ch] = bus_if.wdata;
        end else if (off >= 16) begin
          sh_m[ch][off-16] = bus_if.wdata;
        end
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin : compare
    logic [NCH*NCFG*DW-1:0] ea;
    logic [NCH*DW-1:0] ed;
    if (started) begin
      for (int c = 0; c < NCH; c++) begin
        for (int i = 0; i < NCFG; i++) ea[(c*NCFG+i)*DW +: DW] = ac_m[c][i];
        ed[c*DW +: DW] = dtx_m[c];
      end
      checks++;
      if (active_cfg !== ea) begin
        failures++;
        for (int k = 0; k < NCH * NCFG; k++) begin
          if (active_cfg[k*DW +: DW] !== ea[k*DW +: DW]) begin
            $display("FAIL active_cfg[%0d] actual=%h required=%h", k, active_cfg[k*DW +: DW], ea[k*DW +: DW]);
            break;
          end
        end
      end
      lit("rdata", 32'(bus_if.rdata), 32'(exp_rdata));
      lit("rvalid", 32'(bus_if.rvalid), 32'(exp_rvalid));
      lit("reg_mode", 32'(reg_mode), 32'(rm_m));
      lit("dt_mode", 32'(dt_mode), 32'(dm_m));
      lit("dt_ext", 32'(dt_ext), 32'(ed));
      lit("cfg_updated", 32'(cfg_updated), 32'(exp_upd));
      lit("err_irq", 32'(err_irq), 32'(|err_m));
    end
  end

  // Bus tasks: entered at a negedge, drive for one edge, return at the next negedge.
  task automatic wr(logic [AW-1:0] a, logic [DW-1:0] d);
    bus_if.cs = 1'b1; bus_if.wr = 1'b1; bus_if.addr = a; bus_if.wdata = d;
    @(negedge clk);
    bus_if.cs = 1'b0; bus_if.wr = 1'b0;
  endtask

  task automatic rd_chk(string name, logic [AW-1:0] a, logic [DW-1:0] required);
    bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.addr = a;
    @(negedge clk);
    bus_if.cs = 1'b0; bus_if.rd = 1'b0;
    lit(name, 32'(bus_if.rdata), 32'(required));
    lit({name, "_rvalid"}, 32'(bus_if.rvalid), 32'd1);
  endtask

  initial begin
    rst = 1'b1; busy = '0;
    bus_if.cs = 1'b0; bus_if.rd = 1'b0; bus_if.wr = 1'b0;
    bus_if.addr = '0; bus_if.wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lit("reset_rdata", 32'(bus_if.rdata), 32'h0);
    lit("reset_rvalid", 32'(bus_if.rvalid), 32'h0);
    lit("reset_upd", 32'(cfg_updated), 32'h0);
    lit("reset_irq", 32'(err_irq), 32'h0);

    // Shadow write/readback; active untouched.
    wr(A(0, 'h10), 8'hA1);
    wr(A(1, 'h30), 8'h55);
    wr(A(1, 'h42), 8'h40);
    rd_chk("rb_ch0_10", A(0, 'h10), 8'hA1);
    rd_chk("rb_ch1_30", A(1, 'h30), 8'h55);
    rd_chk("rb_ch1_42", A(1, 'h42), 8'h40);
    lit("act_ch0_0_pre", 32'(act(0, 0)), 32'h0);
    lit("act_ch1_20_pre", 32'(act(1, 'h20)), 32'h0);

    // Idle commit: copy one edge after the commit write.
    wr(A(0, 'h40), 8'h0C);
    wr(A(0, 1), 8'h01);
    lit("commit_not_yet", 32'(act(0, 'h30)), 32'h0);
    @(negedge clk);
    lit("commit_act30", 32'(act(0, 'h30)), 32'h0C);
    lit("commit_act0", 32'(act(0, 0)), 32'hA1);
    lit("commit_upd", 32'(cfg_updated), 32'h1);
    @(negedge clk);
    lit("commit_upd_off", 32'(cfg_updated), 32'h0);
    rd_chk("pend_clear", A(0, 2), 8'h00);
    rd_chk("ctrl_commit_reads0", A(0, 1), 8'h00);
    lit("ch1_untouched", 32'(act(1, 'h20)), 32'h0);

    // Busy commit, issued twice: exactly one copy after busy drops.
    busy[1] = 1'b1;
    wr(A(1, 1), 8'h01);
    wr(A(1, 1), 8'h01);
    repeat (2) @(negedge clk);
    rd_chk("busy_status", A(1, 2), 8'h05);
    lit("busy_act_held", 32'(act(1, 'h20)), 32'h0);
    busy[1] = 1'b0;
    @(negedge clk);
    lit("busy_copy20", 32'(act(1, 'h20)), 32'h55);
    lit("busy_copy32", 32'(act(1, 'h32)), 32'h40);
    lit("busy_upd", 32'(cfg_updated), 32'h2);
    @(negedge clk);
    lit("busy_single_copy", 32'(cfg_updated), 32'h0);
    rd_chk("busy_status_after", A(1, 2), 8'h00);

    // Shadow write on the copy edge: active gets the older value.
    wr(A(0, 'h11), 8'h11);
    busy[0] = 1'b1;
    wr(A(0, 1), 8'h01);
    busy[0] = 1'b0;
    wr(A(0, 'h11), 8'h22);
    lit("race_active", 32'(act(0, 1)), 32'h11);
    lit("race_upd", 32'(cfg_updated), 32'h1);
    rd_chk("race_shadow", A(0, 'h11), 8'h22);

    // DT lock and ERR write-1-to-clear.
    wr(A(0, 1), 8'h06);
    lit("ctrl_modes", 32'({dt_mode[0], reg_mode[0]}), 32'h3);
    wr(A(0, 3), 8'hEE);
    lit("dtlock_irq", 32'(err_irq), 32'h1);
    rd_chk("dtlock_value", A(0, 3), 8'h00);
    rd_chk("dtlock_status", A(0, 2), 8'h02);
    rd_chk("ctrl_read", A(0, 1), 8'h06);
    wr(A(0, 2), 8'h02);
    lit("err_cleared_irq", 32'(err_irq), 32'h0);
    rd_chk("err_cleared", A(0, 2), 8'h00);
    wr(A(0, 1), 8'h00);
    wr(A(0, 3), 8'h5A);
    lit("dt_ext_out", 32'(dt_ext[DW-1:0]), 32'h5A);
    rd_chk("dt_ext_read", A(0, 3), 8'h5A);

    // Illegal offsets, read-only writes, absent channels.
    wr(A(1, 'h60), 8'h33);
    rd_chk("illegal_err", A(1, 2), 8'h02);
    lit("illegal_irq", 32'(err_irq), 32'h1);
    rd_chk("illegal_read", A(1, 'h60), 8'h00);
    rd_chk("version", A(1, 0), 8'h02);
    wr(A(1, 2), 8'h02);
    wr(A(1, 0), 8'hFF);
    rd_chk("version_ro", A(1, 0), 8'h02);
    rd_chk("ro_no_err", A(1, 2), 8'h00);
    wr(A(2, 'h10), 8'h77);
    rd_chk("absent_ch2", A(2, 'h10), 8'h00);
    rd_chk("absent_ch3", A(3, 'h60), 8'h00);
    lit("absent_no_irq", 32'(err_irq), 32'h0);
    rd_chk("absent_no_err", A(0, 2), 8'h00);

    // rd and wr together act as a write only.
    bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.wr = 1'b1;
    bus_if.addr = A(0, 'h12); bus_if.wdata = 8'h3C;
    @(negedge clk);
    bus_if.cs = 1'b0; bus_if.rd = 1'b0; bus_if.wr = 1'b0;
    lit("rdwr_no_rvalid", 32'(bus_if.rvalid), 32'h0);
    rd_chk("rdwr_wrote", A(0, 'h12), 8'h3C);

    // Reset cancels a pending commit.
    busy[0] = 1'b1;
    wr(A(0, 1), 8'h01);
    rd_chk("pre_rst_status", A(0, 2), 8'h05);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    busy[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      lit("rst_no_upd", 32'(cfg_updated), 32'h0);
    end
    rd_chk("rst_status", A(0, 2), 8'h00);
    rd_chk("rst_shadow", A(0, 'h10), 8'h00);
    lit("rst_act0", 32'(act(0, 0)), 32'h0);
    lit("rst_act1", 32'(act(1, 'h20)), 32'h0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
